// File: rtl/iter_shifter_if.sv
// Handshake and data bundle between the stall controller (master) and the
// iterative shift unit (slave).
interface iter_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SW-1:0]    shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;

    modport master (
        output start, op, a, shamt,
        input  busy, done, y
    );

    modport slave (
        input  start, op, a, shamt,
        output busy, done, y
    );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: shifts at most STEP positions per clock
// so the per-cycle barrel depth stays bounded; start/busy/done handshake.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    iter_shifter_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] STEP_W = SW'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_rem;
    logic [1:0]       r_op;
    logic             r_first;
    logic             r_busy;
    logic             r_done;

    logic [SW-1:0]    w_k;
    logic [SW:0]      w_lsh;
    logic [WIDTH-1:0] w_next;

    // Distance for this cycle; zero only on the first step of a shamt=0 request.
    assign w_k   = (r_rem < STEP_W) ? r_rem : STEP_W;
    assign w_lsh = (SW+1)'(WIDTH) - {1'b0, w_k};

    // NOTE: every branch assigns w_next, so no latch is inferred.
    always_comb begin
        case (r_op)
            OP_SLL:  w_next = r_data << w_k;
            OP_SRL:  w_next = r_data >> w_k;
            OP_SRA:  w_next = $unsigned($signed(r_data) >>> w_k);
            default: w_next = (r_data >> w_k) | (r_data << w_lsh);
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and
    // clears the datapath too, since y must read 0 straight after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_op    <= '0;
            r_first <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (r_state == S_RUN)
                assert (r_first || (r_rem != '0));
            case (r_state)
                S_RUN: begin
                    r_data  <= w_next;
                    r_rem   <= r_rem - w_k;
                    r_first <= 1'b0;
                    if (r_rem == w_k) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_data  <= bus.a;
                        r_rem   <= bus.shamt;
                        r_op    <= bus.op;
                        r_first <= 1'b1;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.y    = r_data;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (STEP 4, 1, 31) share stimulus and
// are compared against an arithmetic reference shift and latency formula.
module tb_iter_shifter;
    localparam int W = 32;
    localparam int STEPS [3] = '{4, 1, 31};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(W)) if4 ();
    iter_shifter_if #(.WIDTH(W)) if1 ();
    iter_shifter_if #(.WIDTH(W)) if31 ();

    iter_shifter #(.WIDTH(W), .STEP(4))  u4  (.clk(clk), .reset(reset), .bus(if4));
    iter_shifter #(.WIDTH(W), .STEP(1))  u1  (.clk(clk), .reset(reset), .bus(if1));
    iter_shifter #(.WIDTH(W), .STEP(31)) u31 (.clk(clk), .reset(reset), .bus(if31));

    logic [2:0]   v_done;
    logic [2:0]   v_busy;
    logic [W-1:0] v_y [3];
    assign v_done = {if31.done, if1.done, if4.done};
    assign v_busy = {if31.busy, if1.busy, if4.busy};
    assign v_y[0] = if4.y;
    assign v_y[1] = if1.y;
    assign v_y[2] = if31.y;

    int n_checks = 0;
    int n_errors = 0;

    int           m_lat  [3];
    int           m_busy [3];
    logic [W-1:0] m_y    [3];

    function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] a,
                                               input int sh);
        logic [W-1:0] r;
        case (op)
            2'b00: r = a << sh;
            2'b01: r = a >> sh;
            2'b10: r = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : '0);
            default: for (int i = 0; i < W; i++) r[i] = a[(i + sh) % W];
        endcase
        return r;
    endfunction

    function automatic int exp_n(input int sh, input int step);
        return (sh == 0) ? 1 : (sh + step - 1) / step;
    endfunction

    task automatic drive(input logic st, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [4:0] sh);
        if4.start = st;  if4.op = op;  if4.a = a;  if4.shamt = sh;
        if1.start = st;  if1.op = op;  if1.a = a;  if1.shamt = sh;
        if31.start = st; if31.op = op; if31.a = a; if31.shamt = sh;
    endtask

    task automatic drive_junk(input logic st);
        drive(st, 2'($urandom), $urandom, 5'($urandom));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40 && v_busy != 3'b000; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Issue in cycle 0; record per instance the done cycle, busy cycles and y.
    task automatic run_all(input logic [1:0] op, input logic [W-1:0] a, input logic [4:0] sh,
                           input int pulse_cyc);
        for (int i = 0; i < 3; i++) begin
            m_lat[i] = 0; m_busy[i] = 0; m_y[i] = '0;
        end
        drive(1'b1, op, a, sh);
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (m_lat[i] == 0) begin
                    if (v_done[i]) begin
                        m_lat[i] = c;
                        m_y[i]   = v_y[i];
                    end else if (v_busy[i]) begin
                        m_busy[i]++;
                    end
                end
            end
            drive_junk(c == pulse_cyc);
            if (m_lat[0] != 0 && m_lat[1] != 0 && m_lat[2] != 0) break;
        end
        drive_junk(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (if4.y !== 32'h0) begin
            n_errors++; $display("FAIL reset_y: got %h expected %h", if4.y, 32'h0);
        end
        n_checks++;
        if (v_busy !== 3'b000) begin
            n_errors++; $display("FAIL reset_busy: got %b expected 000", v_busy);
        end
        n_checks++;
        if (v_done !== 3'b000) begin
            n_errors++; $display("FAIL reset_done: got %b expected 000", v_done);
        end
        drive(1'b0, 2'b00, '0, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if4.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle_busy: got %b expected 0", if4.busy);
        end
    endtask

    task automatic test_sll();
        wait_idle();
        run_all(2'b00, 32'h0000_0003, 5'd2, -1);
        n_checks++;
        if (m_lat[0] !== 2) begin
            n_errors++; $display("FAIL sll_latency: got %0d expected 2", m_lat[0]);
        end
        n_checks++;
        if (m_busy[0] !== 1) begin
            n_errors++; $display("FAIL sll_busy_cycles: got %0d expected 1", m_busy[0]);
        end
        n_checks++;
        if (m_y[0] !== 32'h0000_000C) begin
            n_errors++; $display("FAIL sll_y: got %h expected %h", m_y[0], 32'h0000_000C);
        end
        n_checks++;
        if (if4.done !== 1'b0) begin
            n_errors++; $display("FAIL sll_done_width: got %b expected 0", if4.done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (if4.y !== 32'h0000_000C) begin
            n_errors++; $display("FAIL sll_y_hold: got %h expected %h", if4.y, 32'h0000_000C);
        end
    endtask

    task automatic test_sra_srl();
        wait_idle();
        run_all(2'b10, 32'h8000_0000, 5'd31, -1);
        n_checks++;
        if (m_lat[0] !== 9) begin
            n_errors++; $display("FAIL sra_latency: got %0d expected 9", m_lat[0]);
        end
        n_checks++;
        if (m_busy[0] !== 8) begin
            n_errors++; $display("FAIL sra_busy_cycles: got %0d expected 8", m_busy[0]);
        end
        n_checks++;
        if (m_y[0] !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL sra_y: got %h expected %h", m_y[0], 32'hFFFF_FFFF);
        end
        wait_idle();
        run_all(2'b01, 32'h8000_0000, 5'd31, -1);
        n_checks++;
        if (m_lat[0] !== 9) begin
            n_errors++; $display("FAIL srl_latency: got %0d expected 9", m_lat[0]);
        end
        n_checks++;
        if (m_y[0] !== 32'h0000_0001) begin
            n_errors++; $display("FAIL srl_y: got %h expected %h", m_y[0], 32'h0000_0001);
        end
    endtask

    task automatic test_rotr_zero();
        wait_idle();
        run_all(2'b11, 32'h0000_0001, 5'd4, -1);
        n_checks++;
        if (m_lat[0] !== 2) begin
            n_errors++; $display("FAIL rotr_latency: got %0d expected 2", m_lat[0]);
        end
        n_checks++;
        if (m_y[0] !== 32'h1000_0000) begin
            n_errors++; $display("FAIL rotr_y: got %h expected %h", m_y[0], 32'h1000_0000);
        end
        wait_idle();
        run_all(2'($urandom), 32'hDEAD_BEEF, 5'd0, -1);
        n_checks++;
        if (m_lat[0] !== 2) begin
            n_errors++; $display("FAIL zero_latency: got %0d expected 2", m_lat[0]);
        end
        n_checks++;
        if (m_y[0] !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL zero_y: got %h expected %h", m_y[0], 32'hDEAD_BEEF);
        end
        n_checks++;
        if (m_lat[1] !== 2) begin
            n_errors++; $display("FAIL zero_latency_step1: got %0d expected 2", m_lat[1]);
        end
    endtask

    task automatic test_start_ignored();
        wait_idle();
        run_all(2'b10, 32'h8000_0000, 5'd31, 3);
        n_checks++;
        if (m_lat[0] !== 9) begin
            n_errors++; $display("FAIL ignore_latency: got %0d expected 9", m_lat[0]);
        end
        n_checks++;
        if (m_y[0] !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL ignore_y: got %h expected %h", m_y[0], 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd2);
        @(posedge clk); #1;
        drive(1'b1, 2'b11, 32'h0000_0001, 5'd4);
        @(posedge clk); #1;
        n_checks++;
        if (if4.done !== 1'b1 || if4.y !== 32'h0000_000C) begin
            n_errors++;
            $display("FAIL b2b_first_done: got done=%b y=%h expected done=1 y=%h",
                     if4.done, if4.y, 32'h0000_000C);
        end
        @(posedge clk); #1;
        drive_junk(1'b0);
        n_checks++;
        if (if4.busy !== 1'b1) begin
            n_errors++; $display("FAIL b2b_busy: got %b expected 1", if4.busy);
        end
        n_checks++;
        if (if4.done !== 1'b0) begin
            n_errors++; $display("FAIL b2b_done_drop: got %b expected 0", if4.done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (if4.done !== 1'b1) begin
            n_errors++; $display("FAIL b2b_second_done: got %b expected 1", if4.done);
        end
        n_checks++;
        if (if4.y !== 32'h1000_0000) begin
            n_errors++; $display("FAIL b2b_second_y: got %h expected %h", if4.y, 32'h1000_0000);
        end
    endtask

    task automatic test_reset_abort();
        int n_done;
        wait_idle();
        drive(1'b1, 2'b10, 32'h8000_0000, 5'd31);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            drive_junk(1'b0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (if4.y !== 32'h0) begin
            n_errors++; $display("FAIL abort_y: got %h expected %h", if4.y, 32'h0);
        end
        n_checks++;
        if (if4.busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_busy: got %b expected 0", if4.busy);
        end
        n_checks++;
        if (if4.done !== 1'b0) begin
            n_errors++; $display("FAIL abort_done: got %b expected 0", if4.done);
        end
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (if4.done === 1'b1 || if4.busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_errors++; $display("FAIL abort_no_resume: got %0d active cycles expected 0", n_done);
        end
    endtask

    task automatic test_random_sweep();
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [4:0]   sh;
        logic [W-1:0] exp_y;
        for (int t = 0; t < 30; t++) begin
            op = 2'($urandom);
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            exp_y = ref_shift(op, a, int'(sh));
            wait_idle();
            run_all(op, a, sh, -1);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (m_y[i] !== exp_y) begin
                    n_errors++;
                    $display("FAIL sweep_y step=%0d op=%0d a=%h sh=%0d: got %h expected %h",
                             STEPS[i], op, a, sh, m_y[i], exp_y);
                end
                n_checks++;
                if (m_lat[i] !== exp_n(int'(sh), STEPS[i]) + 1) begin
                    n_errors++;
                    $display("FAIL sweep_latency step=%0d sh=%0d: got %0d expected %0d",
                             STEPS[i], sh, m_lat[i], exp_n(int'(sh), STEPS[i]) + 1);
                end
                n_checks++;
                if (m_busy[i] !== exp_n(int'(sh), STEPS[i])) begin
                    n_errors++;
                    $display("FAIL sweep_busy step=%0d sh=%0d: got %0d expected %0d",
                             STEPS[i], sh, m_busy[i], exp_n(int'(sh), STEPS[i]));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_rotr_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
